// File: rtl/ram_pkg.sv
// Shared helpers for the flop-based multi-read-port RAM: address/byte width math,
// mode encodings and the parameter legality check used at elaboration.
package ram_pkg;

  localparam int RdLatencyComb      = 0;
  localparam int RdLatencyReg       = 1;
  localparam int BypassReadOld      = 0;
  localparam int BypassWriteThrough = 1;
  localparam int RstClearArray      = 0;
  localparam int RstKeepArray       = 1;

  localparam int MaxDataWidth = 256;
  localparam int MinDepth     = 2;
  localparam int MaxDepth     = 256;
  localparam int MaxRdPorts   = 8;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

  // A two-word array still needs one address bit, so never return zero.
  function automatic int calc_aw(input int depth);
    return (depth < MinDepth) ? 1 : clog2(depth);
  endfunction

  function automatic int calc_num_bytes(input int data_width, input int byte_width);
    return (byte_width > 0) ? (data_width / byte_width) : 1;
  endfunction

  function automatic bit params_legal(input int data_width, input int byte_width,
                                      input int depth, input int num_rd_ports,
                                      input int rd_latency, input int bypass_mode,
                                      input int rst_mode);
    return (byte_width > 0)
        && (data_width >= 1) && (data_width <= MaxDataWidth)
        && ((data_width % byte_width) == 0)
        && (depth >= MinDepth) && (depth <= MaxDepth)
        && (num_rd_ports >= 1) && (num_rd_ports <= MaxRdPorts)
        && ((rd_latency == RdLatencyComb) || (rd_latency == RdLatencyReg))
        && ((bypass_mode == BypassReadOld) || (bypass_mode == BypassWriteThrough))
        && ((rst_mode == RstClearArray) || (rst_mode == RstKeepArray));
  endfunction

endpackage

// File: rtl/ram_rd_port.sv
// One read port of the flop RAM: range-checked word select, optional write-through
// merge and an optional output register with its valid flag.
module ram_rd_port
  import ram_pkg::*;
#(
  parameter int  data_width  = 8,
  parameter int  byte_width  = 8,
  parameter int  depth       = 8,
  parameter int  rd_latency  = RdLatencyComb,
  parameter int  bypass_mode = BypassReadOld,
  localparam int aw          = calc_aw(depth),
  localparam int num_bytes   = calc_num_bytes(data_width, byte_width)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs_n,
  input  logic                  init_i,
  input  logic                  wr_en_i,
  input  logic [aw-1:0]         wr_addr_i,
  input  logic [num_bytes-1:0]  wr_be_i,
  input  logic [data_width-1:0] wr_data_i,
  input  logic [aw-1:0]         rd_addr_i,
  input  logic [data_width-1:0] mem_i [depth],
  output logic [data_width-1:0] rd_data_o,
  output logic                  rd_valid_o
);

  localparam logic [aw:0] DepthLimit = (aw+1)'(depth);

  logic                  in_range;
  logic [data_width-1:0] word;
  logic [data_width-1:0] merged_word;
  logic [data_width-1:0] data_d;
  logic                  unused_sink;

  assign in_range = ({1'b0, rd_addr_i} < DepthLimit);

  // Addresses past the last word read as zero instead of aliasing onto a real word.
  always_comb begin
    word = '0;
    for (int i = 0; i < depth; i++) begin
      if (in_range && (rd_addr_i == aw'(i))) begin
        word = mem_i[i];
      end
    end
  end

  always_comb begin
    merged_word = word;
    for (int b = 0; b < num_bytes; b++) begin
      if (wr_be_i[b]) begin
        merged_word[b*byte_width +: byte_width] = wr_data_i[b*byte_width +: byte_width];
      end
    end
  end

  if (bypass_mode == BypassWriteThrough) begin : g_write_through
    // A clear on the same edge wins over any write, matching what the array will hold.
    always_comb begin
      data_d = word;
      if (init_i) begin
        data_d = '0;
      end else if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
        data_d = merged_word;
      end
    end
  end else begin : g_read_old
    assign data_d = word;
  end

  if (rd_latency == RdLatencyReg) begin : g_registered
    logic [data_width-1:0] data_q;
    logic                  valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else if (!cs_n) begin
        data_q  <= data_d;
        valid_q <= 1'b1;
      end else begin
        valid_q <= 1'b0;
      end
    end

    assign rd_data_o  = data_q;
    assign rd_valid_o = valid_q;
  end else begin : g_combinational
    assign rd_data_o  = word;
    assign rd_valid_o = 1'b1;
  end

  // Several inputs only matter for some latency/bypass combinations.
  assign unused_sink = ^{clk, rst_n, cs_n, init_i, wr_en_i, wr_addr_i, wr_be_i,
                         wr_data_i, merged_word, data_d};

endmodule

// File: rtl/ram_nr_w_s_dff.sv
// Flop-based RAM with one byte-enabled write port, a synchronous whole-array clear
// and a parametrised number of independent read ports.
module ram_nr_w_s_dff
  import ram_pkg::*;
#(
  parameter int  data_width   = 8,
  parameter int  byte_width   = 8,
  parameter int  depth        = 8,
  parameter int  num_rd_ports = 2,
  parameter int  rd_latency   = RdLatencyComb,
  parameter int  bypass_mode  = BypassReadOld,
  parameter int  rst_mode     = RstClearArray,
  localparam int aw           = calc_aw(depth),
  localparam int num_bytes    = calc_num_bytes(data_width, byte_width)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               cs_n,
  input  logic                               wr_n,
  input  logic                               init_n,
  input  logic [num_bytes-1:0]               wr_be,
  input  logic [aw-1:0]                      wr_addr,
  input  logic [data_width-1:0]              data_in,
  input  logic [num_rd_ports*aw-1:0]         rd_addr,
  output logic [num_rd_ports*data_width-1:0] data_rd_out,
  output logic [num_rd_ports-1:0]            rd_valid
);

  localparam logic [aw:0] DepthLimit = (aw+1)'(depth);

  if (!params_legal(data_width, byte_width, depth, num_rd_ports,
                    rd_latency, bypass_mode, rst_mode)) begin : g_param_check
    $error("ram_nr_w_s_dff: illegal parameter combination");
  end

  logic [data_width-1:0] mem_q [depth];
  logic [data_width-1:0] mem_d [depth];
  logic                  init_active;
  logic                  wr_in_range;
  logic                  wr_active;

  assign init_active = !cs_n && !init_n;
  assign wr_in_range = ({1'b0, wr_addr} < DepthLimit);
  assign wr_active   = !cs_n && !wr_n && init_n && wr_in_range;

  // Next array state: clear beats write; a write only touches enabled bytes of one word.
  always_comb begin
    mem_d = mem_q;
    if (init_active) begin
      for (int i = 0; i < depth; i++) begin
        mem_d[i] = '0;
      end
    end else if (wr_active) begin
      for (int i = 0; i < depth; i++) begin
        if (wr_addr == aw'(i)) begin
          for (int b = 0; b < num_bytes; b++) begin
            if (wr_be[b]) begin
              mem_d[i][b*byte_width +: byte_width] = data_in[b*byte_width +: byte_width];
            end
          end
        end
      end
    end
  end

  if (rst_mode == RstClearArray) begin : g_array_reset
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < depth; i++) begin
          mem_q[i] <= '0;
        end
      end else begin
        mem_q <= mem_d;
      end
    end
  end else begin : g_array_keep
    // Contents survive reset, but nothing may be written while reset is held.
    always_ff @(posedge clk) begin
      if (rst_n) begin
        mem_q <= mem_d;
      end
    end
  end

  for (genvar p = 0; p < num_rd_ports; p++) begin : g_rd_port
    ram_rd_port #(
      .data_width  (data_width),
      .byte_width  (byte_width),
      .depth       (depth),
      .rd_latency  (rd_latency),
      .bypass_mode (bypass_mode)
    ) u_rd_port (
      .clk        (clk),
      .rst_n      (rst_n),
      .cs_n       (cs_n),
      .init_i     (init_active),
      .wr_en_i    (wr_active),
      .wr_addr_i  (wr_addr),
      .wr_be_i    (wr_be),
      .wr_data_i  (data_in),
      .rd_addr_i  (rd_addr[p*aw +: aw]),
      .mem_i      (mem_q),
      .rd_data_o  (data_rd_out[p*data_width +: data_width]),
      .rd_valid_o (rd_valid[p])
    );
  end

endmodule

// File: tb/tb_ram_nr_w_s_dff.sv
// Three RAM configurations driven by shared stimulus and checked every cycle against
// an array-level model; directed literal checks pin the model to known answers.
module tb_ram_nr_w_s_dff;

  localparam int DataWidth = 16;
  localparam int Depth     = 6;
  localparam int Ports     = 2;
  localparam int Aw        = 3;

  logic                   clk     = 1'b0;
  logic                   rstN    = 1'b1;
  logic                   csN     = 1'b1;
  logic                   wrN     = 1'b1;
  logic                   initN   = 1'b1;
  logic [1:0]             wrBe    = '0;
  logic [Aw-1:0]          wrAddr  = '0;
  logic [DataWidth-1:0]   dataIn  = '0;
  logic [Ports*Aw-1:0]    rdAddr  = '0;
  logic [Ports*DataWidth-1:0] d0Data, d1Data, d2Data;
  logic [Ports-1:0]       d0Valid, d1Valid, d2Valid;

  int compared   = 0;
  int mismatched = 0;
  bit checkEn    = 1'b0;

  always #5 clk = ~clk;

  // d0: combinational, array cleared by reset
  ram_nr_w_s_dff #(.data_width(DataWidth), .byte_width(8), .depth(Depth), .num_rd_ports(Ports),
                   .rd_latency(0), .bypass_mode(0), .rst_mode(0)) d0 (
    .clk(clk), .rst_n(rstN), .cs_n(csN), .wr_n(wrN), .init_n(initN), .wr_be(wrBe),
    .wr_addr(wrAddr), .data_in(dataIn), .rd_addr(rdAddr), .data_rd_out(d0Data), .rd_valid(d0Valid));

  // d1: registered read-old, array kept across reset
  ram_nr_w_s_dff #(.data_width(DataWidth), .byte_width(8), .depth(Depth), .num_rd_ports(Ports),
                   .rd_latency(1), .bypass_mode(0), .rst_mode(1)) d1 (
    .clk(clk), .rst_n(rstN), .cs_n(csN), .wr_n(wrN), .init_n(initN), .wr_be(wrBe),
    .wr_addr(wrAddr), .data_in(dataIn), .rd_addr(rdAddr), .data_rd_out(d1Data), .rd_valid(d1Valid));

  // d2: registered write-through, array cleared by reset
  ram_nr_w_s_dff #(.data_width(DataWidth), .byte_width(8), .depth(Depth), .num_rd_ports(Ports),
                   .rd_latency(1), .bypass_mode(1), .rst_mode(0)) d2 (
    .clk(clk), .rst_n(rstN), .cs_n(csN), .wr_n(wrN), .init_n(initN), .wr_be(wrBe),
    .wr_addr(wrAddr), .data_in(dataIn), .rd_addr(rdAddr), .data_rd_out(d2Data), .rd_valid(d2Valid));

  logic [DataWidth-1:0] memClr  [Depth];
  logic [DataWidth-1:0] memKeep [Depth];
  logic [DataWidth-1:0] q1 [Ports];
  logic [DataWidth-1:0] q2 [Ports];
  logic [Ports-1:0]     v1, v2;
  bit keepDefined = 1'b0;
  bit q1Known     = 1'b0;

  function automatic logic [DataWidth-1:0] mergeWord(input logic [DataWidth-1:0] oldWord,
                                                     input logic [DataWidth-1:0] newWord,
                                                     input logic [1:0] be);
    logic [DataWidth-1:0] w;
    w = oldWord;
    for (int b = 0; b < 2; b++) begin
      if (be[b]) w[b*8 +: 8] = newWord[b*8 +: 8];
    end
    return w;
  endfunction

  function automatic logic [DataWidth-1:0] readClr(input logic [Aw-1:0] a);
    return (int'(a) < Depth) ? memClr[a] : '0;
  endfunction

  function automatic logic [DataWidth-1:0] readKeep(input logic [Aw-1:0] a);
    return (int'(a) < Depth) ? memKeep[a] : '0;
  endfunction

  // Reference model: array contents plus what each registered port captured.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < Depth; i++) memClr[i] = '0;
      for (int p = 0; p < Ports; p++) begin
        q1[p] = '0;
        q2[p] = '0;
      end
      v1 = '0;
      v2 = '0;
    end else if (!csN) begin
      for (int p = 0; p < Ports; p++) begin
        logic [Aw-1:0] a;
        a = rdAddr[p*Aw +: Aw];
        q1[p] = readKeep(a);
        if (!initN) q2[p] = '0;
        else if (!wrN && (wrAddr == a) && (int'(a) < Depth)) q2[p] = mergeWord(readClr(a), dataIn, wrBe);
        else q2[p] = readClr(a);
      end
      v1 = '1;
      v2 = '1;
      if (keepDefined) q1Known = 1'b1;
      if (!initN) begin
        for (int i = 0; i < Depth; i++) begin
          memClr[i]  = '0;
          memKeep[i] = '0;
        end
        keepDefined = 1'b1;
      end else if (!wrN && (int'(wrAddr) < Depth)) begin
        memClr[wrAddr]  = mergeWord(memClr[wrAddr], dataIn, wrBe);
        memKeep[wrAddr] = mergeWord(memKeep[wrAddr], dataIn, wrBe);
      end
    end else begin
      v1 = '0;
      v2 = '0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      for (int p = 0; p < Ports; p++) begin
        logic [Aw-1:0] a;
        a = rdAddr[p*Aw +: Aw];
        checkOutput($sformatf("d0_data%0d", p), 32'(d0Data[p*DataWidth +: DataWidth]), 32'(readClr(a)));
        if (q1Known || !rstN)
          checkOutput($sformatf("d1_data%0d", p), 32'(d1Data[p*DataWidth +: DataWidth]), 32'(q1[p]));
        checkOutput($sformatf("d2_data%0d", p), 32'(d2Data[p*DataWidth +: DataWidth]), 32'(q2[p]));
      end
      checkOutput("d0_valid", 32'(d0Valid), 32'(2'b11));
      checkOutput("d1_valid", 32'(d1Valid), 32'(v1));
      checkOutput("d2_valid", 32'(d2Valid), 32'(v2));
    end
  end

  task automatic applyStimulus(input logic cs, input logic wr, input logic init,
                               input logic [1:0] be, input logic [Aw-1:0] wa,
                               input logic [DataWidth-1:0] din,
                               input logic [Aw-1:0] ra0, input logic [Aw-1:0] ra1);
    @(posedge clk);
    #1;
    csN    = cs;
    wrN    = wr;
    initN  = init;
    wrBe   = be;
    wrAddr = wa;
    dataIn = din;
    rdAddr = {ra1, ra0};
  endtask

  initial begin
    #2;
    rstN    = 1'b0;
    checkEn = 1'b1;
    @(negedge clk);
    checkOutput("reset_d1_data", 32'(d1Data), 32'h0);
    checkOutput("reset_d1_valid", 32'(d1Valid), 32'h0);
    checkOutput("reset_d2_data", 32'(d2Data), 32'h0);
    checkOutput("reset_d0_data", 32'(d0Data), 32'h0);
    @(posedge clk);
    #1;
    rstN = 1'b1;

    applyStimulus(0, 1, 0, 2'b00, 3'd0, 16'h0000, 3'd0, 3'd0);

    // first write/read
    applyStimulus(0, 0, 1, 2'b11, 3'd3, 16'h00A5, 3'd3, 3'd3);
    @(negedge clk);
    checkOutput("first_before", 32'(d0Data[15:0]), 32'h0000);
    applyStimulus(0, 1, 1, 2'b00, 3'd0, 16'h0000, 3'd3, 3'd3);
    @(negedge clk);
    checkOutput("first_after_p0", 32'(d0Data[15:0]), 32'h00A5);
    checkOutput("first_after_p1", 32'(d0Data[31:16]), 32'h00A5);
    applyStimulus(0, 1, 1, 2'b00, 3'd0, 16'h0000, 3'd3, 3'd3);
    @(negedge clk);
    checkOutput("first_reg", 32'(d1Data[15:0]), 32'h00A5);
    checkOutput("first_reg_valid", 32'(d1Valid), 32'h3);

    // byte enables
    applyStimulus(0, 0, 1, 2'b11, 3'd2, 16'h1234, 3'd0, 3'd0);
    applyStimulus(0, 0, 1, 2'b01, 3'd2, 16'hABCD, 3'd0, 3'd0);
    applyStimulus(0, 1, 1, 2'b00, 3'd0, 16'h0000, 3'd2, 3'd2);
    @(negedge clk);
    checkOutput("byte_enable", 32'(d0Data[15:0]), 32'h12CD);

    // same-edge bypass
    applyStimulus(0, 0, 1, 2'b11, 3'd5, 16'h0011, 3'd0, 3'd0);
    applyStimulus(0, 0, 1, 2'b11, 3'd5, 16'h0022, 3'd5, 3'd5);
    applyStimulus(0, 1, 1, 2'b00, 3'd0, 16'h0000, 3'd5, 3'd5);
    @(negedge clk);
    checkOutput("bypass_read_old", 32'(d1Data[15:0]), 32'h0011);
    checkOutput("bypass_write_through", 32'(d2Data[15:0]), 32'h0022);

    // init overrides a simultaneous write
    for (int i = 0; i < Depth; i++) applyStimulus(0, 0, 1, 2'b11, 3'(i), 16'hFFFF, 3'd0, 3'd0);
    applyStimulus(0, 0, 0, 2'b11, 3'd1, 16'h0033, 3'd1, 3'd1);
    @(negedge clk);
    checkOutput("init_pre_clear", 32'(d0Data[15:0]), 32'hFFFF);
    applyStimulus(0, 1, 1, 2'b00, 3'd0, 16'h0000, 3'd1, 3'd4);
    @(negedge clk);
    checkOutput("init_addr1", 32'(d0Data[15:0]), 32'h0000);
    checkOutput("init_addr4", 32'(d0Data[31:16]), 32'h0000);
    checkOutput("init_reg_old", 32'(d1Data[15:0]), 32'hFFFF);
    checkOutput("init_reg_through", 32'(d2Data[15:0]), 32'h0000);

    // out-of-range write and read
    applyStimulus(0, 0, 1, 2'b11, 3'd6, 16'h0077, 3'd6, 3'd0);
    applyStimulus(0, 1, 1, 2'b00, 3'd0, 16'h0000, 3'd6, 3'd0);
    @(negedge clk);
    checkOutput("oor_read", 32'(d0Data[15:0]), 32'h0000);
    checkOutput("oor_no_alias", 32'(d0Data[31:16]), 32'h0000);

    // chip select blocks writes and drops valid
    applyStimulus(1, 0, 1, 2'b11, 3'd4, 16'h0044, 3'd4, 3'd4);
    applyStimulus(0, 1, 1, 2'b00, 3'd0, 16'h0000, 3'd4, 3'd4);
    @(negedge clk);
    checkOutput("cs_no_write", 32'(d0Data[15:0]), 32'h0000);
    checkOutput("cs_d1_valid", 32'(d1Valid), 32'h0);
    checkOutput("cs_d2_valid", 32'(d2Valid), 32'h0);

    // reset keeps the array only when rst_mode=1; a write under reset is lost
    applyStimulus(0, 0, 1, 2'b11, 3'd4, 16'h0044, 3'd4, 3'd4);
    applyStimulus(0, 1, 1, 2'b00, 3'd0, 16'h0000, 3'd4, 3'd4);
    @(negedge clk);
    checkOutput("pre_reset_word", 32'(d0Data[15:0]), 32'h0044);
    applyStimulus(0, 0, 1, 2'b11, 3'd0, 16'h5555, 3'd4, 3'd4);
    #1;
    rstN = 1'b0;
    @(negedge clk);
    checkOutput("midreset_d1_data", 32'(d1Data), 32'h0);
    checkOutput("midreset_d1_valid", 32'(d1Valid), 32'h0);
    checkOutput("midreset_d0_cleared", 32'(d0Data[15:0]), 32'h0000);
    applyStimulus(0, 1, 1, 2'b00, 3'd0, 16'h0000, 3'd4, 3'd4);
    rstN = 1'b1;
    applyStimulus(0, 1, 1, 2'b00, 3'd0, 16'h0000, 3'd0, 3'd0);
    @(negedge clk);
    checkOutput("kept_after_reset", 32'(d1Data[15:0]), 32'h0044);
    applyStimulus(0, 1, 1, 2'b00, 3'd0, 16'h0000, 3'd0, 3'd0);
    @(negedge clk);
    checkOutput("write_lost_in_reset", 32'(d1Data[15:0]), 32'h0000);

    for (int n = 0; n < 400; n++) begin
      applyStimulus(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 15) != 0), 2'($urandom_range(0, 3)),
                    3'($urandom_range(0, 7)), 16'($urandom),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    @(negedge clk);
    checkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
